// File: rtl/uart_pkg.sv
// Shared types and constants for the configurable UART transmitter.
// Holds the serialiser state encoding, the parity-mode values and a frame-size helper.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Number of serial bit periods in one frame.
  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with one extra pointer bit, so full and empty are told apart
// by the pointer MSBs; exposes the current occupancy.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     wr_en,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             push;
  logic             pop;

  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are meaningful.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Buffered UART transmitter: words enter a FIFO over valid/ready and leave LSB-first
// with configurable bit period, width, parity and stop bits; frames chain with no gap.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = PAR_NONE,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [DATA_BITS-1:0]          i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_level
);

  localparam int CNT_W = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  tx_state_e              state;
  tx_state_e              state_next;
  logic [CNT_W-1:0]       cnt;
  logic [IDX_W-1:0]       idx;
  logic [DATA_BITS-1:0]   shift;
  logic [DATA_BITS-1:0]   fifo_data;
  logic                   par_bit;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pop;
  logic                   tick;
  logic                   tx_next;

  sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (i_clk),
    .rst     (i_rst),
    .wr_data (i_data),
    .wr_en   (i_valid),
    .rd_en   (pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (o_level)
  );

  assign o_ready = !fifo_full;
  assign o_busy  = !fifo_empty || (state != ST_IDLE);
  // With CLK_PER_BIT = 1 the timer stays at 0, which is also its terminal count.
  assign tick    = (cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= ST_IDLE;
    else       state <= state_next;
  end

  // NOTE: every output of this block gets a default first, so no path leaves a latch.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_START;
        end
      end
      ST_START:  if (tick) state_next = ST_DATA;
      ST_DATA: begin
        if (tick && idx == DATA_LAST)
          state_next = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
      end
      ST_PARITY: if (tick) state_next = ST_STOP;
      ST_STOP: begin
        if (tick && idx == STOP_LAST) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            state_next = ST_START;
          end else begin
            state_next = ST_IDLE;
          end
        end
      end
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_next = 1'b1;
    unique case (state)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift[0];
      ST_PARITY: tx_next = par_bit;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      o_tx    <= 1'b1;
    end else begin
      o_tx <= tx_next;

      if (tick || state == ST_IDLE) cnt <= '0;
      else                          cnt <= cnt + 1'b1;

      // The index restarts whenever a bit boundary also changes state.
      if (tick) begin
        if (state_next != state)                       idx <= '0;
        else if (state == ST_DATA || state == ST_STOP) idx <= idx + 1'b1;
      end

      if (pop) begin
        shift   <= fifo_data;
        par_bit <= (PARITY == PAR_EVEN) ? ^fifo_data : ~(^fifo_data);
      end else if (state == ST_DATA && tick) begin
        shift <= {1'b0, shift[DATA_BITS-1:1]};
      end
    end
  end

endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Parametrised, buffered UART transmitter: the next generation of the team's fixed 8N1 transmit-only UART. It accepts words over a valid/ready handshake into a small FIFO and serialises them LSB-first with a configurable bit period, data width, parity and stop-bit count. Back-to-back frames go out with no idle gap. It sits between a byte-producing client (debug/command logic) and the board TX pin.

## Interface
- CLK_PER_BIT, default 16: clock cycles per serial bit, ≥1.
- DATA_BITS, default 8: data bits per frame, 5..9.
- PARITY, default 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, default 1: 1 or 2.
- FIFO_DEPTH, default 4: power of two, ≥2.
- i_clk  in  1  single clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_data  in  DATA_BITS  word to transmit; sampled on the accepting edge.
- i_valid  in  1  i_data is valid.
- o_ready  out  1  FIFO can accept; equals !full.
- o_tx  out  1  serial line, idle high; registered.
- o_busy  out  1  high while the FIFO is non-empty or a frame is in progress.
- o_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

## Operation
- Push: on an edge with i_valid & o_ready, i_data is written at the write pointer. When full, i_valid is ignored and data is held upstream.
- Pop: the FSM pops when it is in IDLE, or in the last cycle of the final stop bit, and the FIFO is non-empty. A popped word loads the shift register.
- Simultaneous push and pop: both take effect and o_level is unchanged. Pointers are $clog2(FIFO_DEPTH)+1 bits with natural wrap; full/empty come from the MSB compare.
- FSM states are IDLE, START, DATA, PARITY, STOP:
  - IDLE → START on pop.
  - START → DATA after one bit period.
  - DATA → PARITY (when PARITY≠0) or STOP after DATA_BITS bit periods.
  - PARITY → STOP after one bit period.
  - STOP → START (when the FIFO is non-empty, popping in that same cycle) or IDLE, after STOP_BITS bit periods.
- Bit timer counts 0..CLK_PER_BIT-1. It clears on every bit boundary and on each START entry. Every bit lasts exactly CLK_PER_BIT cycles.
- Bit index counts 0..DATA_BITS-1 in DATA and 0..STOP_BITS-1 in STOP.
- o_tx per state: 1 in IDLE, 0 in START, shift[0] in DATA (shift right each bit), the parity bit in PARITY, 1 in STOP.
- Parity is the XOR of the popped word, computed at pop:
  - Even: bit = XOR, so the total count of ones is even.
  - Odd: bit = ~XOR, so the total count of ones is odd.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × CLK_PER_BIT cycles.

## Timing
- Reset values:
  - o_tx = 1, o_ready = 1, o_busy = 0, o_level = 0.
  - FSM = IDLE, pointers, timer and index = 0.
- Reset mid-frame: o_tx goes high asynchronously, the frame is abandoned and the FIFO is emptied. After release, the first start bit needs a new push.
- Latency: a word accepted at edge E into an empty, idle block is popped at E+1. o_tx falls after E+2 and the start bit lasts CLK_PER_BIT cycles.
- o_level updates on the edge after a push or pop. o_ready deasserts on the edge where the level reaches FIFO_DEPTH.
- o_busy rises on the edge after the first push. It falls on the edge that returns the FSM to IDLE with the FIFO empty, which is the end of the last stop bit.
- CLK_PER_BIT = 1: each bit lasts one cycle and the timer is permanently at its terminal count. It must still function correctly.

## Structure
- Package uart_pkg holds:
  - the FSM state enum;
  - the parity-mode constants PAR_NONE/PAR_ODD/PAR_EVEN;
  - a function returning the frame length in bits.
- Sub-module sync_fifo holds the parametrised storage and the level/full/empty logic, with DATA_BITS width and FIFO_DEPTH depth.
- The serialiser, bit timer and output register stay in uart_tx_cfg.

## Test plan
- CLK_PER_BIT=4, 8N1, push 0xA5 → o_tx is 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. Start bit begins 2 cycles after accept; o_busy is high for 40+1 cycles.
- PARITY=2, push 0x07 → parity bit 1. PARITY=1, push 0x07 → parity bit 0. PARITY=1, push 0x00 → parity bit 1.
- DATA_BITS=7, STOP_BITS=2, CLK_PER_BIT=3, push 0x41 → frame of 30 cycles, with the stop level held for 6 cycles.
- FIFO_DEPTH=4, push 6 words on consecutive cycles with i_valid held → o_ready drops when o_level=4 and rises again on each pop. All 6 frames are contiguous, with no idle cycle between stop and start, and the order is preserved.
- Assert i_rst during data bit 3 while 2 words are queued → o_tx=1 immediately, o_level=0, o_busy=0. A subsequent push transmits normally.
- CLK_PER_BIT=1, 8N1, push 0xFF then 0x00 → 20 consecutive correct bit cycles.
